// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types and constants for the SM83 interrupt sequencer
package sm83_pkg;

    localparam int         NUM_IRQS_DEF   = 8;
    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam logic [7:0] VEC_STRIDE_DEF = 8'd8;
    localparam logic [2:0] DISP_MCYCLES   = 3'd5;
    // Vector is resolved after the PCH push, so late requests can still win.
    localparam logic [2:0] LATCH_MCYC     = 3'd3;

    typedef logic [NUM_IRQS_DEF-1:0] irq_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALT = 2'd1,
        DISP = 2'd2
    } int_state_t;

endpackage

// File: rtl/sm83_irq_prio.sv
// rtl/sm83_irq_prio.sv - lowest-index-wins priority encoder for interrupt lines
module sm83_irq_prio #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic          valid
);

    always_comb begin
        idx    = '0;
        onehot = '0;
        valid  = |req;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm83_int_ctl.sv
// rtl/sm83_int_ctl.sv - SM83 IME, interrupt dispatch and HALT sequencer
module sm83_int_ctl
    import sm83_pkg::*;
#(
    parameter int         NUM_IRQS   = NUM_IRQS_DEF,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [7:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                mcyc_end,
    input  logic                instr_end,
    input  logic                op_ei,
    input  logic                op_di,
    input  logic                op_reti,
    input  logic                op_halt,
    input  logic [NUM_IRQS-1:0] irq,
    output logic                ime,
    output logic                int_req,
    output logic [2:0]          disp_mcyc,
    output logic [7:0]          vec,
    output logic [NUM_IRQS-1:0] iack,
    output logic                halted,
    output logic                halt_bug
);

    localparam int IW = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    int_state_t          state, state_nxt;
    logic                ei_pend, ei_pend_nxt;
    logic                ime_nxt, int_req_nxt, halted_nxt, halt_bug_nxt;
    logic [2:0]          disp_nxt;
    logic [7:0]          vec_nxt, vec_calc;
    logic [NUM_IRQS-1:0] iack_nxt;

    logic [IW-1:0]       p_idx;
    logic [NUM_IRQS-1:0] p_onehot;
    logic                p_valid;

    logic ime_eff, do_ei, do_halt, accept;

    sm83_irq_prio #(.N(NUM_IRQS), .IW(IW)) u_prio (
        .req    (irq),
        .idx    (p_idx),
        .onehot (p_onehot),
        .valid  (p_valid)
    );

    assign vec_calc = VEC_BASE + 8'(p_idx) * VEC_STRIDE;

    always_comb begin
        state_nxt    = state;
        ime_nxt      = ime;
        ei_pend_nxt  = ei_pend;
        int_req_nxt  = int_req;
        disp_nxt     = disp_mcyc;
        vec_nxt      = vec;
        iack_nxt     = '0;
        halted_nxt   = halted;
        halt_bug_nxt = 1'b0;
        accept       = 1'b0;

        // Op flags should be one-hot; resolve overlaps as di > reti > ei > halt.
        ime_eff = (ime | ei_pend | op_reti) & ~op_di;
        do_ei   = op_ei & ~op_di & ~op_reti;
        do_halt = op_halt & ~op_di & ~op_reti & ~op_ei;

        unique case (state)
            IDLE: begin
                if (instr_end) begin
                    if (ime_eff && p_valid) begin
                        accept = 1'b1;
                    end else begin
                        ime_nxt     = ime_eff;
                        ei_pend_nxt = do_ei;
                        if (do_halt) begin
                            if (p_valid) begin
                                halt_bug_nxt = 1'b1;
                            end else begin
                                halted_nxt = 1'b1;
                                state_nxt  = HALT;
                            end
                        end
                    end
                end
            end
            HALT: begin
                if (mcyc_end && p_valid) begin
                    halted_nxt = 1'b0;
                    if (ime) accept    = 1'b1;
                    else     state_nxt = IDLE;
                end
            end
            DISP: begin
                if (mcyc_end) begin
                    if (disp_mcyc == LATCH_MCYC) begin
                        vec_nxt  = p_valid ? vec_calc : 8'h00;
                        iack_nxt = p_onehot;
                    end
                    if (disp_mcyc == DISP_MCYCLES) begin
                        int_req_nxt = 1'b0;
                        disp_nxt    = 3'd0;
                        state_nxt   = IDLE;
                    end else begin
                        disp_nxt = disp_mcyc + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            state_nxt   = DISP;
            disp_nxt    = 3'd1;
            int_req_nxt = 1'b1;
            ime_nxt     = 1'b0;
            ei_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            ime       <= 1'b0;
            ei_pend   <= 1'b0;
            int_req   <= 1'b0;
            disp_mcyc <= 3'd0;
            vec       <= 8'h00;
            iack      <= '0;
            halted    <= 1'b0;
            halt_bug  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ime       <= ime_nxt;
            ei_pend   <= ei_pend_nxt;
            int_req   <= int_req_nxt;
            disp_mcyc <= disp_nxt;
            vec       <= vec_nxt;
            iack      <= iack_nxt;
            halted    <= halted_nxt;
            halt_bug  <= halt_bug_nxt;
        end
    end

endmodule

// File: tb/tb_sm83_int_ctl.sv
// tb/tb_sm83_int_ctl.sv - self-checking bench for sm83_int_ctl
module tb_sm83_int_ctl;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_EI   = 4'h1;
    localparam logic [3:0] OP_DI   = 4'h2;
    localparam logic [3:0] OP_RETI = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h8;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       mcyc_end = 1'b0;
    logic       instr_end = 1'b0;
    logic       op_ei = 1'b0, op_di = 1'b0, op_reti = 1'b0, op_halt = 1'b0;
    logic [7:0] irq = 8'h00;
    logic       ime, int_req, halted, halt_bug;
    logic [2:0] disp_mcyc;
    logic [7:0] vec, iack;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] sb_exp;
    logic [2:0]  prev_mc = 3'd0;
    int          req_clks = 0;

    sm83_int_ctl dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .mcyc_end  (mcyc_end),
        .instr_end (instr_end),
        .op_ei     (op_ei),
        .op_di     (op_di),
        .op_reti   (op_reti),
        .op_halt   (op_halt),
        .irq       (irq),
        .ime       (ime),
        .int_req   (int_req),
        .disp_mcyc (disp_mcyc),
        .vec       (vec),
        .iack      (iack),
        .halted    (halted),
        .halt_bug  (halt_bug)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One M-cycle of four clocks; strobes and op flags only on the last clock.
    task automatic mcyc(input logic last, input logic [3:0] ops);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mcyc_end  = (k == 3);
            instr_end = last && (k == 3);
            {op_halt, op_reti, op_di, op_ei} = (last && k == 3) ? ops : 4'h0;
        end
        @(posedge clk);
        #1;
        mcyc_end  = 1'b0;
        instr_end = 1'b0;
        {op_halt, op_reti, op_di, op_ei} = 4'h0;
    endtask

    task automatic instr(input logic [3:0] ops);
        mcyc(1'b1, ops);
    endtask

    task automatic run_disp(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            chk("disp_mcyc", 32'(disp_mcyc), k);
            chk("int_req_held", 32'(int_req), 1);
            mcyc(1'b0, OP_NOP);
        end
    endtask

    // Scoreboard consumer: the vector latch edge is where disp_mcyc goes 3 -> 4.
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_mc  = 3'd0;
            req_clks = 0;
        end else begin
            if (prev_mc == 3'd3 && disp_mcyc == 3'd4) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("vec", 32'(vec), 32'(sb_exp[15:8]));
                    chk("iack", 32'(iack), 32'(sb_exp[7:0]));
                end
            end else if (iack != 8'h00) begin
                chk("iack_spurious", 32'(iack), 0);
            end
            if (int_req) begin
                req_clks++;
            end else if (req_clks != 0) begin
                chk("int_req_len", req_clks, 20);
                req_clks = 0;
            end
            prev_mc = disp_mcyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ime", 32'(ime), 0);
        chk("rst_int_req", 32'(int_req), 0);
        chk("rst_disp_mcyc", 32'(disp_mcyc), 0);
        chk("rst_vec", 32'(vec), 0);
        chk("rst_iack", 32'(iack), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_halt_bug", 32'(halt_bug), 0);
        n_reset = 1'b1;

        // EI delay
        irq = 8'h04;
        instr(OP_EI);
        chk("ei_no_req", 32'(int_req), 0);
        chk("ei_ime", 32'(ime), 0);
        sb.push_back({8'h50, 8'h04});
        instr(OP_NOP);
        chk("ei_nop_req", 32'(int_req), 1);
        chk("ei_ime_cleared", 32'(ime), 0);
        run_disp(1, 5);
        chk("ei_req_done", 32'(int_req), 0);
        chk("ei_disp_idle", 32'(disp_mcyc), 0);
        irq = 8'h00;
        instr(OP_NOP);
        chk("ei_vec_hold", 32'(vec), 32'h50);

        // DI cancels a pending EI
        irq = 8'h01;
        instr(OP_EI);
        instr(OP_DI);
        chk("di_no_req", 32'(int_req), 0);
        instr(OP_NOP);
        chk("di_nop_no_req", 32'(int_req), 0);
        chk("di_ime", 32'(ime), 0);
        irq = 8'h00;

        // Priority, then late irq change must not alter vec
        instr(OP_EI);
        instr(OP_NOP);
        chk("prio_ime_set", 32'(ime), 1);
        irq = 8'h06;
        sb.push_back({8'h48, 8'h02});
        instr(OP_NOP);
        chk("prio_req", 32'(int_req), 1);
        run_disp(1, 3);
        irq = 8'h80;
        run_disp(4, 5);
        chk("prio_vec_hold", 32'(vec), 32'h48);
        irq = 8'h00;

        // Cancelled dispatch
        instr(OP_EI);
        instr(OP_NOP);
        irq = 8'h06;
        sb.push_back({8'h00, 8'h00});
        instr(OP_NOP);
        run_disp(1, 1);
        irq = 8'h00;
        run_disp(2, 5);
        chk("cancel_req_done", 32'(int_req), 0);

        // RETI enables acceptance at its own boundary
        irq = 8'h08;
        sb.push_back({8'h58, 8'h08});
        instr(OP_RETI);
        chk("reti_req", 32'(int_req), 1);
        run_disp(1, 5);
        irq = 8'h00;

        // HALT wake with ime=0
        instr(OP_HALT);
        chk("halt0_halted", 32'(halted), 1);
        mcyc(1'b0, OP_NOP);
        chk("halt0_stay", 32'(halted), 1);
        irq = 8'h08;
        @(negedge clk);
        @(negedge clk);
        chk("halt0_between", 32'(halted), 1);
        mcyc(1'b0, OP_NOP);
        chk("halt0_woke", 32'(halted), 0);
        chk("halt0_no_req", 32'(int_req), 0);
        irq = 8'h00;

        // HALT wake with ime=1
        instr(OP_EI);
        instr(OP_NOP);
        instr(OP_HALT);
        chk("halt1_halted", 32'(halted), 1);
        chk("halt1_ime", 32'(ime), 1);
        irq = 8'h20;
        sb.push_back({8'h68, 8'h20});
        mcyc(1'b0, OP_NOP);
        chk("halt1_woke", 32'(halted), 0);
        chk("halt1_req", 32'(int_req), 1);
        run_disp(1, 5);
        irq = 8'h00;

        // Halt bug
        irq = 8'h10;
        instr(OP_HALT);
        chk("hbug_pulse", 32'(halt_bug), 1);
        chk("hbug_halted", 32'(halted), 0);
        chk("hbug_no_req", 32'(int_req), 0);
        @(posedge clk);
        #1;
        chk("hbug_one_clk", 32'(halt_bug), 0);
        irq = 8'h00;

        // Reset during M4
        instr(OP_EI);
        instr(OP_NOP);
        irq = 8'h01;
        sb.push_back({8'h40, 8'h01});
        instr(OP_NOP);
        run_disp(1, 3);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_ime", 32'(ime), 0);
        chk("arst_int_req", 32'(int_req), 0);
        chk("arst_disp_mcyc", 32'(disp_mcyc), 0);
        chk("arst_vec", 32'(vec), 0);
        chk("arst_iack", 32'(iack), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_halt_bug", 32'(halt_bug), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        instr(OP_NOP);
        chk("post_rst_no_req", 32'(int_req), 0);
        chk("post_rst_halted", 32'(halted), 0);
        instr(OP_EI);
        sb.push_back({8'h40, 8'h01});
        instr(OP_NOP);
        chk("post_rst_req", 32'(int_req), 1);
        run_disp(1, 5);
        irq = 8'h00;
        instr(OP_NOP);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
